// File: rtl/serial_half_subtractor.sv
// Bit-serial a - b, LSB first, one subtractor cell plus registered borrow; done pulses WIDTH+1 cycles after accept.
// No backpressure: start is taken only in IDLE or DONE, and is ignored while busy.
module serial_half_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bit_d;
  logic             borrow_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    bit_d     = sa_q[0] ^ sb_q[0] ^ borrow_q;
    borrow_nx = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & borrow_q);
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    sr_d      = sr_q;
    diff_d    = diff_q;
    borrow_d  = borrow_q;
    bout_d    = bout_q;
    cnt_d     = cnt_q;
    case (state_q)
      // DONE accepts start like IDLE so back-to-back operations lose no cycle.
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          sa_d     = a;
          sb_d     = b;
          sr_d     = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        sr_d     = {bit_d, sr_q[WIDTH-1:1]};
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        borrow_d = borrow_nx;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d  = sr_d;
          bout_d  = borrow_nx;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_half_subtractor.sv
// Directed bench for serial_half_subtractor: an 8-bit instance for latency, hold, back-to-back and reset
// behaviour, and a 2-bit instance swept exhaustively; expected results travel through scoreboard queues.
module tb_serial_half_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b, diff;
  logic       busy, done, bout;
  logic       start2;
  logic [1:0] a2, b2, diff2;
  logic       busy2, done2, bout2;

  always #5 clk = ~clk;

  serial_half_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  serial_half_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
  );

  int         n_checks = 0;
  int         n_fails  = 0;
  logic [8:0] sb_q[$];
  logic [2:0] sb2_q[$];
  logic [7:0] prev_diff;
  logic       prev_bout;
  logic [2:0] prev2;
  logic       seen2;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y);
    return {1'b0, x} - {1'b0, y};
  endfunction

  task automatic push8(input logic [7:0] x, input logic [7:0] y);
    a = x;
    b = y;
    sb_q.push_back(model8(x, y));
  endtask

  task automatic got_done8();
    logic [8:0] e;
    if (sb_q.size() == 0) begin
      chk("sb_nonempty", 16'(sb_q.size()), 16'd1);
    end else begin
      e = sb_q.pop_front();
      chk("diff", 16'(diff), 16'(e[7:0]));
      chk("bout", 16'(bout), 16'(e[8]));
      prev_diff = e[7:0];
      prev_bout = e[8];
    end
  endtask

  // One operation with start pulses and operand noise injected while busy.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y);
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    push8(x, y);
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      chk("busy_done_excl", 16'(busy & done), 16'd0);
      if (done) begin
        chk("latency", 16'(k), 16'd9);
        got_done8();
        seen  = 1'b1;
        start = 1'b0;
      end else begin
        chk("busy_run", 16'(busy), 16'd1);
        chk("diff_hold", 16'(diff), 16'(prev_diff));
        chk("bout_hold", 16'(bout), 16'(prev_bout));
        start = k[0];
        a     = 8'($urandom);
        b     = 8'($urandom);
      end
    end
    chk("done_seen", 16'(seen), 16'd1);
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_no_done", 16'({busy, done}), 16'd0);
    end
  endtask

  task automatic back2back();
    logic [7:0] xa[4];
    logic [7:0] xb[4];
    int idx, ndone, since;
    xa = '{8'h10, 8'h01, 8'h80, 8'h7F};
    xb = '{8'h01, 8'h10, 8'h7F, 8'h80};
    @(negedge clk);
    start = 1'b1;
    push8(xa[0], xb[0]);
    idx = 1; ndone = 0; since = 0;
    for (int c = 0; c < 100 && ndone < 4; c++) begin
      @(negedge clk);
      since++;
      chk("b2b_excl", 16'(busy & done), 16'd0);
      if (done) begin
        chk("b2b_period", 16'(since), 16'd9);
        got_done8();
        ndone++;
        since = 0;
        if (idx < 4) push8(xa[idx], xb[idx]);
        else start = 1'b0;
        idx++;
      end else begin
        chk("b2b_busy", 16'(busy), 16'd1);
        chk("b2b_hold", 16'(diff), 16'(prev_diff));
      end
    end
    chk("b2b_count", 16'(ndone), 16'd4);
    start = 1'b0;
  endtask

  initial begin
    logic [2:0] e2;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    start2 = 1'b0; a2 = '0; b2 = '0;
    prev_diff = '0; prev_bout = 1'b0; prev2 = '0;
    #12;
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_diff", 16'(diff), 16'd0);
    chk("rst_bout", 16'(bout), 16'd0);
    chk("rst2_outs", 16'({busy2, done2, diff2, bout2}), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h05, 8'h03);
    run_op(8'h03, 8'h05);
    run_op(8'h00, 8'h01);
    run_op(8'hFF, 8'hFF);
    run_op(8'h9C, 8'h27);

    back2back();

    // Asynchronous reset while count == 4; the operation must vanish.
    @(negedge clk);
    start = 1'b1;
    push8(8'hA5, 8'h3C);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", 16'(busy), 16'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", 16'(busy), 16'd0);
    chk("arst_done", 16'(done), 16'd0);
    chk("arst_diff", 16'(diff), 16'd0);
    chk("arst_bout", 16'(bout), 16'd0);
    sb_q.delete();
    prev_diff = '0;
    prev_bout = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) begin
      @(negedge clk);
      chk("post_rst_no_done", 16'({busy, done}), 16'd0);
    end
    run_op(8'h3C, 8'hA5);

    for (int i = 0; i < 16; i++) begin
      logic [3:0] iv;
      iv = 4'(i);
      @(negedge clk);
      a2 = iv[3:2];
      b2 = iv[1:0];
      start2 = 1'b1;
      sb2_q.push_back({1'b0, iv[3:2]} - {1'b0, iv[1:0]});
      seen2 = 1'b0;
      for (int k = 1; k <= 10 && !seen2; k++) begin
        @(negedge clk);
        start2 = 1'b0;
        chk("w2_excl", 16'(busy2 & done2), 16'd0);
        if (done2) begin
          e2 = sb2_q.pop_front();
          chk("w2_latency", 16'(k), 16'd3);
          chk("w2_diff", 16'(diff2), 16'(e2[1:0]));
          chk("w2_bout", 16'(bout2), 16'(e2[2]));
          prev2 = e2;
          seen2 = 1'b1;
        end else begin
          chk("w2_hold", 16'({bout2, diff2}), 16'(prev2));
        end
      end
      chk("w2_done_seen", 16'(seen2), 16'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
